// File: rtl/player_move_pkg.sv
// Shared move codes, FSM states and grid defaults for the player mover
// and the collision detector it feeds.
package player_move_pkg;

    typedef logic [2:0] move_t;

    localparam move_t MOVE_NONE  = 3'b000;
    localparam move_t MOVE_RIGHT = 3'b100;
    localparam move_t MOVE_UP    = 3'b001;
    localparam move_t MOVE_LEFT  = 3'b010;
    localparam move_t MOVE_DOWN  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam int GRID_W_DEF = 20;
    localparam int GRID_H_DEF = 15;

endpackage

// File: rtl/player_move_if.sv
// Mover <-> collision detector link: proposed move and current position
// out, resolved position back.
interface player_move_if;
    import player_move_pkg::*;

    move_t      move;
    logic [4:0] cur_x;
    logic [4:0] cur_y;
    logic [4:0] new_x;
    logic [4:0] new_y;

    modport master (
        output move, cur_x, cur_y,
        input  new_x, new_y
    );

    modport slave (
        input  move, cur_x, cur_y,
        output new_x, new_y
    );

endinterface

// File: rtl/player_move_ctrl_timer.sv
// Loadable down-counter shared by the settle (WAIT) and auto-repeat
// (HOLD) windows of the player mover.
module move_rate_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/player_move_ctrl.sv
// Rate-limited player mover: keys -> detector request -> settle -> commit.
// Define BOUNDS_GUARD_EN to reject off-grid commits and add bound_err.
module player_move_ctrl
    import player_move_pkg::*;
#(
    parameter int         MOVE_DIV   = 25_000_000,
    parameter int         SETTLE_CYC = 2,
    parameter logic [4:0] SPAWN_X    = 5'd1,
    parameter logic [4:0] SPAWN_Y    = 5'd1
`ifdef BOUNDS_GUARD_EN
    ,
    parameter int         GRID_W     = GRID_W_DEF,
    parameter int         GRID_H     = GRID_H_DEF
`endif
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          respawn,
    input  logic          key_right,
    input  logic          key_up,
    input  logic          key_left,
    input  logic          key_down,
    player_move_if.master det,
    output logic [4:0]    player_x,
    output logic [4:0]    player_y,
    output logic          moved,
    output logic          blocked,
    output logic          busy
`ifdef BOUNDS_GUARD_EN
    ,
    output logic          bound_err
`endif
);

    localparam int CW = $clog2(MOVE_DIV + 1);
    localparam logic [CW-1:0] SET_LD  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(MOVE_DIV - 1);

    state_t        state;
    move_t         move_q;
    move_t         key_code;
    logic          t_load;
    logic          t_dec;
    logic          t_zero;
    logic [CW-1:0] t_val;
    logic          pos_same;

    always_comb begin
        key_code = MOVE_NONE;
        priority case (1'b1)
            key_right: key_code = MOVE_RIGHT;
            key_up:    key_code = MOVE_UP;
            key_left:  key_code = MOVE_LEFT;
            key_down:  key_code = MOVE_DOWN;
            default:   key_code = MOVE_NONE;
        endcase
    end

    always_comb begin
        t_load = 1'b0;
        t_dec  = 1'b0;
        t_val  = HOLD_LD;
        unique case (state)
            S_REQ: begin
                t_load = 1'b1;
                t_val  = SET_LD;
            end
            S_WAIT: begin
                t_load = t_zero;
                t_dec  = !t_zero;
            end
            S_HOLD:  t_dec = !t_zero;
            default: ;
        endcase
    end

    move_rate_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    assign pos_same = (det.new_x == player_x) && (det.new_y == player_y);

`ifdef BOUNDS_GUARD_EN
    logic oob;
    assign oob = (int'(det.new_x) >= GRID_W) || (int'(det.new_y) >= GRID_H);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            move_q    <= MOVE_NONE;
            player_x  <= SPAWN_X;
            player_y  <= SPAWN_Y;
            moved     <= 1'b0;
            blocked   <= 1'b0;
            busy      <= 1'b0;
`ifdef BOUNDS_GUARD_EN
            bound_err <= 1'b0;
`endif
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            if (respawn) begin
                // respawn overrides a commit landing on the same edge
                state     <= S_IDLE;
                move_q    <= MOVE_NONE;
                player_x  <= SPAWN_X;
                player_y  <= SPAWN_Y;
                busy      <= 1'b0;
`ifdef BOUNDS_GUARD_EN
                bound_err <= 1'b0;
`endif
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (key_code != MOVE_NONE) begin
                            move_q <= key_code;
                            state  <= S_REQ;
                            busy   <= 1'b1;
                        end
                    end
                    S_REQ: state <= S_WAIT;
                    S_WAIT: begin
                        if (t_zero) begin
                            move_q <= MOVE_NONE;
                            state  <= S_HOLD;
`ifdef BOUNDS_GUARD_EN
                            if (oob) begin
                                blocked   <= 1'b1;
                                bound_err <= 1'b1;
                            end else
`endif
                            begin
                                player_x <= det.new_x;
                                player_y <= det.new_y;
                                moved    <= !pos_same;
                                blocked  <= pos_same;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (t_zero) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign det.move  = move_q;
    assign det.cur_x = player_x;
    assign det.cur_y = player_y;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a behavioural detector and a
// commit scoreboard (MOVE_DIV=4, SETTLE_CYC=2, spawn (1,1)).
module tb_player_move_ctrl;
    import player_move_pkg::*;

    typedef struct {
        logic       mv;
        logic [4:0] x;
        logic [4:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic respawn = 1'b0;
    logic key_right = 1'b0;
    logic key_up = 1'b0;
    logic key_left = 1'b0;
    logic key_down = 1'b0;
    logic [4:0] player_x;
    logic [4:0] player_y;
    logic moved;
    logic blocked;
    logic busy;
`ifdef BOUNDS_GUARD_EN
    logic bound_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int det_mode = 1;
    exp_t sb[$];
    int pulse_cyc[$];

    player_move_if det_if ();

    player_move_ctrl #(
        .MOVE_DIV   (4),
        .SETTLE_CYC (2),
        .SPAWN_X    (5'd1),
        .SPAWN_Y    (5'd1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .respawn   (respawn),
        .key_right (key_right),
        .key_up    (key_up),
        .key_left  (key_left),
        .key_down  (key_down),
        .det       (det_if),
        .player_x  (player_x),
        .player_y  (player_y),
        .moved     (moved),
        .blocked   (blocked),
        .busy      (busy)
`ifdef BOUNDS_GUARD_EN
        ,
        .bound_err (bound_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // detector: 0 = wall (echo), 1 = free move, 2 = off-grid answer
    always_comb begin
        det_if.new_x = det_if.cur_x;
        det_if.new_y = det_if.cur_y;
        if (det_mode == 2) begin
            det_if.new_x = 5'd25;
            det_if.new_y = 5'd1;
        end else if (det_mode == 1) begin
            case (det_if.move)
                MOVE_RIGHT: det_if.new_x = det_if.cur_x + 5'd1;
                MOVE_LEFT:  det_if.new_x = det_if.cur_x - 5'd1;
                MOVE_UP:    det_if.new_y = det_if.cur_y - 5'd1;
                MOVE_DOWN:  det_if.new_y = det_if.cur_y + 5'd1;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        logic to;
        to = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        check(tag, to, 1'b0);
    endtask

    task automatic push(input logic mv, input logic [4:0] x,
                        input logic [4:0] y);
        exp_t e;
        e.mv = mv;
        e.x  = x;
        e.y  = y;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (resetn && (moved || blocked)) begin
            check("both_pulse", moved & blocked, 1'b0);
            if (moved) pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexp_pulse", {moved, blocked}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_moved", moved, e.mv);
                check("sb_x", player_x, e.x);
                check("sb_y", player_y, e.y);
            end
        end
    end

    initial begin
        repeat (3) step();
        check("rst_x", player_x, 5'd1);
        check("rst_y", player_y, 5'd1);
        check("rst_move", det_if.move, MOVE_NONE);
        check("rst_busy", busy, 1'b0);
        check("rst_pulse", {moved, blocked}, 2'b00);
        resetn = 1'b1;
        step();

        // blocked against a wall
        det_mode = 0;
        key_up = 1'b1;
        push(1'b0, 5'd1, 5'd1);
        step();
        key_up = 1'b0;
        check("up_move", det_if.move, MOVE_UP);
        wait_idle("blk_idle");
        check("blk_x", player_x, 5'd1);

        // single move right
        det_mode = 1;
        key_right = 1'b1;
        push(1'b1, 5'd2, 5'd1);
        step();
        key_right = 1'b0;
        check("r_move1", det_if.move, MOVE_RIGHT);
        check("r_busy", busy, 1'b1);
        step();
        check("r_move2", det_if.move, MOVE_RIGHT);
        check("r_curx", det_if.cur_x, 5'd1);
        step();
        check("r_move3", det_if.move, MOVE_RIGHT);
        step();
        check("r_move_end", det_if.move, MOVE_NONE);
        check("r_curx_new", det_if.cur_x, 5'd2);
        wait_idle("r_idle");

        // auto-repeat with key held 24 cycles
        pulse_cyc.delete();
        key_right = 1'b1;
        push(1'b1, 5'd3, 5'd1);
        push(1'b1, 5'd4, 5'd1);
        push(1'b1, 5'd5, 5'd1);
        repeat (24) step();
        key_right = 1'b0;
        wait_idle("ar_idle");
        check("ar_count", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check("ar_gap1", pulse_cyc[1] - pulse_cyc[0], 8);
            check("ar_gap2", pulse_cyc[2] - pulse_cyc[1], 8);
        end

        // priority
        key_right = 1'b1;
        key_down = 1'b1;
        push(1'b1, 5'd6, 5'd1);
        step();
        key_right = 1'b0;
        key_down = 1'b0;
        check("pri_rd", det_if.move, MOVE_RIGHT);
        wait_idle("pri1_idle");
        key_left = 1'b1;
        key_down = 1'b1;
        push(1'b1, 5'd5, 5'd1);
        step();
        key_down = 1'b0;
        check("pri_ld", det_if.move, MOVE_LEFT);
        key_left = 1'b0;
        wait_idle("pri2_idle");
        key_left = 1'b1;
        push(1'b1, 5'd4, 5'd1);
        step();
        key_left = 1'b0;
        wait_idle("l_idle");
        check("pos4_x", player_x, 5'd4);

        // respawn while in WAIT
        key_right = 1'b1;
        step();
        key_right = 1'b0;
        step();
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        check("rsp_x", player_x, 5'd1);
        check("rsp_y", player_y, 5'd1);
        check("rsp_move", det_if.move, MOVE_NONE);
        check("rsp_busy", busy, 1'b0);
        repeat (4) step();
        check("rsp_quiet", busy, 1'b0);

        // async reset in HOLD
        key_right = 1'b1;
        push(1'b1, 5'd2, 5'd1);
        step();
        key_right = 1'b0;
        repeat (4) step();
        check("hold_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("ar_x", player_x, 5'd1);
        check("ar_move", det_if.move, MOVE_NONE);
        check("ar_busy", busy, 1'b0);
        step();
        resetn = 1'b1;
        step();

`ifdef BOUNDS_GUARD_EN
        det_mode = 2;
        key_down = 1'b1;
        push(1'b0, 5'd1, 5'd1);
        step();
        key_down = 1'b0;
        wait_idle("bg_idle");
        check("bg_err", bound_err, 1'b1);
        check("bg_x", player_x, 5'd1);
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        check("bg_clr", bound_err, 1'b0);
        det_mode = 1;
`endif

        repeat (2) step();
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
